// File: rtl/rr_mux_pkg.sv
// Shared types and the rotating priority search for the round-robin N-channel mux.
// Channel count is bounded by MAX_CH so the search can live in one non-parameterised function.
package rr_mux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N_CH  = 4;
    localparam int MAX_CH    = 32;
    localparam int MAX_IDX_W = 5;

    // Output stage state; the encoding is exactly out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic                 vld;
        logic [MAX_IDX_W-1:0] idx;
    } grant_t;

    // First set request scanning ptr, ptr+1, ... n_ch-1, 0, ... ptr-1 (ptr must be < n_ch).
    function automatic grant_t rr_search(input logic [MAX_CH-1:0]    req,
                                         input logic [MAX_IDX_W:0]   n_ch,
                                         input logic [MAX_IDX_W-1:0] ptr);
        grant_t               g;
        logic [MAX_IDX_W:0]   pos;
        g = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            pos = {1'b0, ptr} + k[MAX_IDX_W:0];
            if (pos >= n_ch) pos = pos - n_ch;
            if (!g.vld && (k[MAX_IDX_W:0] < n_ch) && req[pos[MAX_IDX_W-1:0]]) begin
                g.vld = 1'b1;
                g.idx = pos[MAX_IDX_W-1:0];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arb_n.sv
// Purely combinational rotating-priority arbiter: picks one request starting at ptr.
// The caller owns ptr; tying it to zero gives fixed lowest-index-wins priority.
module rr_arb_n
    import rr_mux_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] gnt_onehot,
    output logic [CH_W-1:0] gnt_idx,
    output logic            gnt_vld
);

    localparam logic [MAX_IDX_W:0] N_CH_L = (MAX_IDX_W+1)'(N_CH);

    grant_t res;

    // NOTE: every output of a combinational block gets a default before any branch, or a latch is inferred.
    always_comb begin
        res        = rr_search(MAX_CH'(req), N_CH_L, MAX_IDX_W'(ptr));
        gnt_vld    = res.vld;
        gnt_idx    = res.idx[CH_W-1:0];
        gnt_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            gnt_onehot[i] = res.vld && (res.idx == MAX_IDX_W'(i));
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel round-robin mux with a single registered valid/ready output stage.
// Define RR_MUX_FIXED_PRIO_EN for fixed lowest-index priority (no rotating pointer).
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N_CH  = DEF_N_CH,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    state_t           state_q;
    state_t           state_d;
    logic [CH_W-1:0]  ptr;
    logic [N_CH-1:0]  gnt_onehot;
    logic [CH_W-1:0]  gnt_idx;
    logic             gnt_vld;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] ch_data [N_CH];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    rr_arb_n #(
        .N_CH(N_CH),
        .CH_W(CH_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_onehot(gnt_onehot),
        .gnt_idx   (gnt_idx),
        .gnt_vld   (gnt_vld)
    );

    assign out_valid = (state_q == ST_FULL);
    assign load      = !out_valid || out_ready;
    // Nothing is accepted while reset is held, so no word is lost into a clearing register.
    assign xfer      = load && gnt_vld && reset_n;
    assign in_ready  = {N_CH{xfer}} & gnt_onehot;

    always_comb begin
        state_d = state_q;
        if (load) state_d = gnt_vld ? ST_FULL : ST_EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
            out_ch   <= '0;
        end else if (xfer) begin
            out_data <= ch_data[gnt_idx];
            out_ch   <= gnt_idx;
        end
    end

`ifdef RR_MUX_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  ptr <= '0;
        else if (xfer) ptr <= (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
    end
`endif

endmodule
